// File: rtl/sv_trigger_pkg.sv
// rtl/sv_trigger_pkg.sv - shared types and default widths for the trigger link
package sv_trigger_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int STAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    EXPOSE  = 2'd2,
    HOLDOFF = 2'd3
  } trig_rx_state_t;

endpackage

// File: rtl/sv_sat_counter.sv
// rtl/sv_sat_counter.sv - saturating up-counter with synchronous clear
module sv_sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  // Clear takes priority over a coincident increment.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/sv_trigger_exposure_ctrl.sv
// rtl/sv_trigger_exposure_ctrl.sv - trigger receiver: delay, exposure pulse, hold-off
module sv_trigger_exposure_ctrl
  import sv_trigger_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_trigger,
  input  logic              i_enable,
  input  logic [CNT_W-1:0]  i_delay,
  input  logic [CNT_W-1:0]  i_width,
  input  logic [CNT_W-1:0]  i_holdoff,
  input  logic              i_cnt_clr,
  output logic              o_expose,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [STAT_W-1:0] o_trig_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
);

  trig_rx_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] width_q, holdoff_q;
  logic             trig_q;
  logic             ev;
  logic             accept;
  logic             reject;

  assign ev = i_trigger & ~trig_q;

  // The counter holds (remaining cycles - 1) so a full-scale duration fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (ev && i_enable) begin
          accept = 1'b1;
          if (i_delay != '0) begin
            state_nxt = DELAY;
            cnt_nxt   = i_delay - CNT_W'(1);
          end else begin
            state_nxt = EXPOSE;
            cnt_nxt   = width_m1(i_width);
          end
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          state_nxt = EXPOSE;
          cnt_nxt   = width_m1(width_q);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      EXPOSE: begin
        if (cnt == '0) begin
          if (holdoff_q != '0) begin
            state_nxt = HOLDOFF;
            cnt_nxt   = holdoff_q - CNT_W'(1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Any event outside IDLE is a miss, including on the edge that returns to IDLE.
    if (state != IDLE) begin
      reject = ev;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      trig_q    <= 1'b0;
      width_q   <= '0;
      holdoff_q <= '0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      trig_q    <= i_trigger;
      o_overrun <= reject;
      if (accept) begin
        width_q   <= i_width;
        holdoff_q <= i_holdoff;
      end
    end
  end

  assign o_expose = (state == EXPOSE);
  assign o_busy   = (state != IDLE);

  sv_sat_counter #(.W(STAT_W)) u_trig_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_cnt_clr),
    .i_inc   (accept),
    .o_count (o_trig_cnt)
  );

  sv_sat_counter #(.W(STAT_W)) u_miss_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_cnt_clr),
    .i_inc   (reject),
    .o_count (o_miss_cnt)
  );

endmodule

// File: tb/tb_sv_trigger_exposure_ctrl.sv
// tb/tb_sv_trigger_exposure_ctrl.sv - scoreboard bench for sv_trigger_exposure_ctrl
module tb_sv_trigger_exposure_ctrl;

  localparam int CNT_W  = 16;
  localparam int STAT_W = 32;

  typedef struct {
    int start;
    int len;
  } exp_t;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_trigger;
  logic              i_enable;
  logic [CNT_W-1:0]  i_delay;
  logic [CNT_W-1:0]  i_width;
  logic [CNT_W-1:0]  i_holdoff;
  logic              i_cnt_clr;
  logic              o_expose;
  logic              o_busy;
  logic              o_overrun;
  logic [STAT_W-1:0] o_trig_cnt;
  logic [STAT_W-1:0] o_miss_cnt;

  logic              s_trigger;
  logic              s_cnt_clr;
  logic              s_expose;
  logic              s_busy;
  logic              s_overrun;
  logic [3:0]        s_trig_cnt;
  logic [3:0]        s_miss_cnt;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ovr_q[$];

  always #5 clk = ~clk;

  sv_trigger_exposure_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_trigger  (i_trigger),
    .i_enable   (i_enable),
    .i_delay    (i_delay),
    .i_width    (i_width),
    .i_holdoff  (i_holdoff),
    .i_cnt_clr  (i_cnt_clr),
    .o_expose   (o_expose),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun),
    .o_trig_cnt (o_trig_cnt),
    .o_miss_cnt (o_miss_cnt)
  );

  // Narrow-statistics instance for saturation checks.
  sv_trigger_exposure_ctrl #(.CNT_W(CNT_W), .STAT_W(4)) dut_s (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_trigger  (s_trigger),
    .i_enable   (1'b1),
    .i_delay    (16'd0),
    .i_width    (16'd0),
    .i_holdoff  (16'd0),
    .i_cnt_clr  (s_cnt_clr),
    .o_expose   (s_expose),
    .o_busy     (s_busy),
    .o_overrun  (s_overrun),
    .o_trig_cnt (s_trig_cnt),
    .o_miss_cnt (s_miss_cnt)
  );

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the edge index k at which the event is sampled; leaves cyc == k.
  task automatic trig_pulse(output int k);
    i_trigger = 1'b1;
    k = cyc + 1;
    step(1);
    i_trigger = 1'b0;
  endtask

  // Monitor: exposure windows and overrun pulses, cycle numbered as edge index + 1.
  initial begin
    bit   prev;
    int   start;
    int   oc;
    exp_t e;
    prev  = 1'b0;
    start = 0;
    forever begin
      @(negedge clk);
      if (o_expose === 1'b1 && !prev) start = cyc + 1;
      if (o_expose !== 1'b1 && prev) begin
        chk("expose_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("expose_start", start, e.start);
          chk("expose_len", cyc + 1 - start, e.len);
        end
      end
      prev = (o_expose === 1'b1);
      if (o_overrun === 1'b1) begin
        chk("overrun_expected", ovr_q.size() > 0, 1);
        if (ovr_q.size() > 0) begin
          oc = ovr_q.pop_front();
          chk("overrun_cycle", cyc + 1, oc);
        end
      end
    end
  end

  initial begin
    int k;
    int k2;
    i_reset   = 1'b1;
    i_trigger = 1'b0;
    i_enable  = 1'b0;
    i_delay   = '0;
    i_width   = '0;
    i_holdoff = '0;
    i_cnt_clr = 1'b0;
    s_trigger = 1'b0;
    s_cnt_clr = 1'b0;
    step(10);
    i_reset = 1'b0;
    step(1);

    chk("rst_expose", o_expose, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_trig_cnt", o_trig_cnt, 0);
    chk("rst_miss_cnt", o_miss_cnt, 0);

    // D=3 W=4 H=2
    i_delay = 16'd3; i_width = 16'd4; i_holdoff = 16'd2; i_enable = 1'b1;
    trig_pulse(k);
    exp_q.push_back('{k + 4, 4});
    step(8);
    chk("t2_busy_k9", o_busy, 1);
    step(1);
    chk("t2_busy_k10", o_busy, 0);
    chk("t2_trig_cnt", o_trig_cnt, 1);

    // Clear, then D=W=H=0 back-to-back
    i_cnt_clr = 1'b1;
    step(1);
    i_cnt_clr = 1'b0;
    chk("clr_trig_cnt", o_trig_cnt, 0);
    i_delay = 16'd0; i_width = 16'd0; i_holdoff = 16'd0;
    trig_pulse(k);
    exp_q.push_back('{k + 1, 1});
    step(2);
    trig_pulse(k2);
    exp_q.push_back('{k2 + 1, 1});
    step(3);
    chk("t3_trig_cnt", o_trig_cnt, 2);
    chk("t3_miss_cnt", o_miss_cnt, 0);

    // Reject during DELAY; mid-sequence input changes ignored
    i_delay = 16'd5; i_width = 16'd5; i_holdoff = 16'd0;
    trig_pulse(k);
    exp_q.push_back('{k + 6, 5});
    step(2);
    trig_pulse(k2);
    ovr_q.push_back(k2 + 1);
    i_delay = 16'd1; i_width = 16'd1;
    step(12);
    chk("t4_miss_cnt", o_miss_cnt, 1);
    chk("t4_trig_cnt", o_trig_cnt, 3);

    // Event on the EXPOSE->IDLE edge is rejected
    i_delay = 16'd0; i_width = 16'd2; i_holdoff = 16'd0;
    trig_pulse(k);
    exp_q.push_back('{k + 1, 2});
    step(1);
    trig_pulse(k2);
    ovr_q.push_back(k2 + 1);
    step(4);
    chk("t4b_miss_cnt", o_miss_cnt, 2);
    chk("t4b_trig_cnt", o_trig_cnt, 4);
    chk("t4b_busy", o_busy, 0);

    // Disabled trigger ignored; held-high trigger is one event
    i_delay = 16'd1; i_width = 16'd2; i_holdoff = 16'd1; i_enable = 1'b0;
    trig_pulse(k);
    step(20);
    chk("t5_dis_trig_cnt", o_trig_cnt, 4);
    chk("t5_dis_miss_cnt", o_miss_cnt, 2);
    i_enable  = 1'b1;
    i_trigger = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{k + 2, 2});
    step(20);
    i_trigger = 1'b0;
    step(2);
    chk("t5_held_trig_cnt", o_trig_cnt, 5);
    chk("t5_held_miss_cnt", o_miss_cnt, 2);

    // Reset during EXPOSE
    i_delay = 16'd2; i_width = 16'd10; i_holdoff = 16'd0;
    trig_pulse(k);
    exp_q.push_back('{k + 3, 3});
    step(4);
    chk("t6_expose_before_rst", o_expose, 1);
    i_reset = 1'b1;
    step(1);
    chk("t6_expose", o_expose, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_trig_cnt", o_trig_cnt, 0);
    chk("t6_miss_cnt", o_miss_cnt, 0);
    i_reset = 1'b0;
    step(2);

    // Saturation at 4 bits, then clear coincident with accept
    repeat (17) begin
      s_trigger = 1'b1;
      step(1);
      s_trigger = 1'b0;
      step(2);
    end
    chk("sat_trig_cnt", s_trig_cnt, 15);
    chk("sat_miss_cnt", s_miss_cnt, 0);
    s_trigger = 1'b1;
    s_cnt_clr = 1'b1;
    step(1);
    s_trigger = 1'b0;
    s_cnt_clr = 1'b0;
    chk("clr_vs_inc", s_trig_cnt, 0);
    chk("clr_vs_inc_busy", s_busy, 1);
    step(3);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("ovr_q_drained", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
